muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit; successor to the separate multiplier and divider blocks.
//  Serves MULT/MULTU/DIV/DIVU from the control unit with a single start/ready handshake.
//  Results go to the HI/LO registers: HI = upper product half or remainder; LO = lower half or quotient.
//  Radix-2 shift-add multiply and restoring divide run one bit per clock; a single datapath is shared by both.
// PARAMETERS
//  WIDTH   32  operand width; hi/lo are WIDTH bits each; legal range 4..64.
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
//  clk       in   1      system clock; all state changes on rising edge
//  reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      request; sampled only in IDLE
//  op        in   2      00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start
//  a         in   WIDTH  multiplicand / dividend; sampled with start
//  b         in   WIDTH  multiplier / divisor; sampled with start
//  hi        out  WIDTH  product[2W-1:W] or remainder; registered
//  lo        out  WIDTH  product[W-1:0] or quotient; registered
//  busy      out  1      high in any state other than IDLE
//  ready     out  1      one-cycle pulse: hi/lo valid (or div_zero reported)
//  div_zero  out  1      pulses together with ready when a DIV/DIVU had b==0
// BEHAVIOUR
//  Reset: state=IDLE. hi=lo=0. busy=ready=div_zero=0. Counter and internal accumulators cleared.
//   Reset asserted mid-operation aborts the operation. hi/lo return to 0. No ready is produced.
//  States: IDLE, CALC, FIXUP, DONE. ready = (state==DONE). busy = (state!=IDLE).
//  IDLE: on start=1 at edge E0, latch op/a/b.
//   Signed ops: latch magnitudes and result-sign flags.
//   DIV/DIVU with b==0: go straight to DONE with div_zero=1; hi/lo keep their previous values.
//   All other cases: go to CALC with counter=0.
//  CALC: one iteration per edge.
//   MUL: if multiplier LSB=1, add multiplicand to the upper accumulator; then shift {acc,mplr} right 1.
//   DIV: shift {rem,quo} left 1; trial-subtract the divisor; keep the difference and set quo LSB if it is non-negative.
//   After WIDTH iterations (edge E_W), go to FIXUP.
//  FIXUP (edge E_{W+1}): apply sign correction and write hi/lo, then go to DONE.
//   MULT: negate the 2W-bit product if the operand signs differ.
//   DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
//  DONE: ready=1 (and div_zero if flagged) for exactly one cycle, then IDLE unconditionally.
//  Latency: start sampled at E0 -> ready high in the cycle after E_{W+1} (W+2 cycles).
//   Divide by zero: ready high in the cycle after E0.
//  start while busy (CALC/FIXUP/DONE) is ignored, not queued. Inputs may change freely after E0.
//  Back-to-back: start may be asserted in the IDLE cycle immediately after DONE.
//  Signed division truncates toward zero. -2^(W-1) / -1 gives lo=-2^(W-1) (wrap), hi=0, no flag.
//  MULTU/DIVU treat operands as unsigned; the full 2W-bit product is never truncated.
//  hi/lo change only in FIXUP (and on reset); they hold stable otherwise.
// TESTING (WIDTH=32)
//  MULT a=7 b=-3 -> after 34 cycles ready pulse; hi=FFFFFFFF lo=FFFFFFEB; busy low the next cycle.
//  MULTU a=b=FFFFFFFF -> hi=FFFFFFFE lo=00000001.
//  DIV: a=-7 b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. a=80000000 b=FFFFFFFF -> lo=80000000, hi=0, div_zero=0.
//  DIVU a=7 b=0 (hi/lo preloaded 5/9) -> ready+div_zero one cycle after start; hi=5 lo=9 unchanged.
//  Start held high during CALC with new a/b -> ignored; result matches the first op; ready pulses once.
//  Reset pulse at iteration 10 of a DIV -> hi=lo=0, busy=0, no ready; next MULTU 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit for MULT, MULTU, DIV and DIVU.
// One shared accumulator/shift datapath produces one bit per clock; HI/LO are written once per operation.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] opnd;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    signed_op;
    logic                    a_neg;
    logic                    b_neg;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          rem_sh;
    logic [WIDTH:0]          diff;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign a_s       = a;
    assign b_s       = b;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op && (a_s < 0);
    assign b_neg     = signed_op && (b_s < 0);

    // acc holds the upper product half during MUL and the partial remainder during DIV;
    // low holds the multiplier (shifting out) or the dividend/quotient (shifting through).
    always_comb begin
        mul_sum = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
        rem_sh  = {acc, low[WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            acc      <= '0;
            low      <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (op[1]) begin
                            low  <= neg_w(a, a_neg);
                            opnd <= neg_w(b, b_neg);
                        end else begin
                            low  <= neg_w(b, b_neg);
                            opnd <= neg_w(a, a_neg);
                        end
                        if (op[1] && (b == '0)) begin
                            state    <= DONE;
                            ready    <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        low <= {mul_sum[0], low[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (is_div) begin
                        lo <= neg_w(low, neg_lo);
                        hi <= neg_w(acc, neg_hi);
                    end else begin
                        {hi, lo} <= neg_2w({acc, low}, neg_lo);
                    end
                    state <= DONE;
                    ready <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ready    <= 1'b0;
                    div_zero <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: directed MULT/MULTU/DIV/DIVU vectors,
// divide-by-zero, start-while-busy, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         ready;
    logic         div_zero;

    typedef struct packed {
        logic         dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .ready(ready), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got hi=%h lo=%h, expected no ready", hi, lo);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "_hi"}, 64'(hi), 64'(e.hi));
                check({n, "_lo"}, 64'(lo), 64'(e.lo));
                check({n, "_dz"}, 64'(div_zero), 64'(e.dz));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edz, input int elat, input int hold);
        exp_t e;
        int   c0;
        int   lat;
        e.dz = edz;
        e.hi = eh;
        e.lo = el;
        exp_q.push_back(e);
        name_q.push_back(name);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        c0 = cyc;
        if (hold > 0) begin
            op = ~o;
            a  = ~av;
            b  = bv + 32'd3;
            repeat (hold) @(posedge clk);
            #1;
        end
        start = 1'b0;
        a     = 32'h0BAD_F00D;
        b     = 32'h0000_0000;
        do begin
            @(negedge clk);
        end while (ready !== 1'b1 && (cyc - c0) < 200);
        lat = cyc - c0 + 1;
        check({name, "_latency"}, 64'(lat), 64'(elat));
        @(negedge clk);
        check({name, "_busy_after"}, 64'(busy), 64'(0));
        check({name, "_ready_once"}, 64'(ready), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ready", 64'(ready), 64'(0));
        check("reset_dz", 64'(div_zero), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_op("mult_7_m3",     2'b00, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 0);
        run_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 0);
        run_op("mult_m5_m6",    2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 1'b0, 34, 0);
        run_op("mult_min_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34, 0);
        run_op("multu_shift",   2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 34, 0);
        run_op("div_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 0);
        run_op("div_7_m2",      2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34, 0);
        run_op("div_min_m1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 0);
        run_op("div_100_7",     2'b10, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E, 1'b0, 34, 0);
        run_op("divu_max_2",    2'b11, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 34, 0);
        run_op("divu_95_10",    2'b11, 32'd95,       32'd10,       32'h0000_0005, 32'h0000_0009, 1'b0, 34, 0);
        run_op("divu_by_zero",  2'b11, 32'd7,        32'd0,        32'h0000_0005, 32'h0000_0009, 1'b1, 1,  0);
        run_op("div_by_zero",   2'b10, 32'hFFFF_FFF0, 32'd0,        32'h0000_0005, 32'h0000_0009, 1'b1, 1,  0);
        run_op("multu_held",    2'b01, 32'd6,        32'd7,        32'h0000_0000, 32'h0000_002A, 1'b0, 34, 5);

        // Abort a DIV partway through its iterations with an asynchronous reset.
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd1000;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_ready", 64'(ready), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_ready_busy", 64'(busy), 64'(0));

        run_op("multu_3_4",     2'b01, 32'd3,        32'd4,        32'h0000_0000, 32'h0000_000C, 1'b0, 34, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
